// File: rtl/spi_master_multi_if.sv
`default_nettype none
// ============================================================================
// spi_master_multi_if : host handshake and SPI pin bundle for spi_master_multi
// Revision: 1.0
// ============================================================================
interface spi_master_multi_if #(
  parameter int WIDTH = 8,
  parameter int NCS   = 4,
  parameter int SW    = (NCS > 1) ? $clog2(NCS) : 1
);
  logic             send;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic [SW-1:0]    sel;
  logic             cpol;
  logic             cpha;
  logic [WIDTH-1:0] dataO;
  logic             arrived;
  logic             SCLK;
  logic             MOSI;
  logic             MISO;
  logic [NCS-1:0]   CS;

  modport master (
    input  send, data, sel, cpol, cpha, MISO,
    output ready, dataO, arrived, SCLK, MOSI, CS
  );

  modport slave (
    output send, data, sel, cpol, cpha, MISO,
    input  ready, dataO, arrived, SCLK, MOSI, CS
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// spi_master_multi : full-duplex SPI master, parametrised width/divider/order,
//                    per-transfer CPOL/CPHA and NCS active-low chip selects
// Revision: 1.0
// ============================================================================
module spi_master_multi #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int NCS       = 4,
  parameter int MSB_FIRST = 1,
  parameter int SW        = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_multi_if.master bus
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div;
  logic [HW-1:0]    r_half;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic             r_cpol;
  logic             r_cpha;

  logic w_div_end;
  logic w_last;
  logic w_lead;
  logic w_sel_ok;

  assign w_div_end = (r_div == DW'(DIV - 1));
  assign w_last    = (r_half == HW'(2 * WIDTH - 1));
  // Even half-period indices end on a leading SCLK edge.
  assign w_lead    = ~r_half[0];
  assign w_sel_ok  = (32'(bus.sel) < 32'(NCS));

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    return (MSB_FIRST != 0) ? ((v << 1) | WIDTH'(b))
                            : ((v >> 1) | (WIDTH'(b) << (WIDTH - 1)));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_half      <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      bus.ready   <= 1'b1;
      bus.arrived <= 1'b0;
      bus.dataO   <= '0;
      bus.SCLK    <= 1'b0;
      bus.MOSI    <= 1'b0;
      bus.CS      <= '1;
    end else begin
      bus.arrived <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.send && w_sel_ok) begin
            r_state   <= SETUP;
            r_div     <= '0;
            r_half    <= '0;
            r_cpol    <= bus.cpol;
            r_cpha    <= bus.cpha;
            bus.ready <= 1'b0;
            bus.SCLK  <= bus.cpol;
            bus.CS    <= ~(NCS'(1) << bus.sel);
            // With cpha=0 the first bit must be on the wire before the first leading edge.
            if (!bus.cpha) begin
              bus.MOSI <= first_bit(bus.data);
              r_tx     <= shift_out(bus.data);
            end else begin
              r_tx     <= bus.data;
            end
          end
        end

        SETUP: begin
          r_div <= r_div + 1'b1;
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          r_div <= r_div + 1'b1;
          if (w_div_end) begin
            r_div    <= '0;
            r_half   <= r_half + 1'b1;
            bus.SCLK <= ~bus.SCLK;
            if (w_lead) begin
              if (!r_cpha) begin
                r_rx <= shift_in(r_rx, bus.MISO);
              end else begin
                bus.MOSI <= first_bit(r_tx);
                r_tx     <= shift_out(r_tx);
              end
            end else begin
              if (r_cpha) begin
                r_rx <= shift_in(r_rx, bus.MISO);
              end else if (!w_last) begin
                bus.MOSI <= first_bit(r_tx);
                r_tx     <= shift_out(r_tx);
              end
            end
            if (w_last) begin
              r_state  <= HOLD;
              bus.SCLK <= r_cpol;
            end
          end
        end

        HOLD: begin
          r_div <= r_div + 1'b1;
          if (w_div_end) begin
            r_div       <= '0;
            r_state     <= IDLE;
            bus.CS      <= '1;
            bus.ready   <= 1'b1;
            bus.arrived <= 1'b1;
            bus.dataO   <= r_rx;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// tb_spi_master_multi : directed vector bench for spi_master_multi
// Revision: 1.0
// ============================================================================
module tb_spi_master_multi;
  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  always #5 clk = ~clk;

  spi_master_multi_if #(.WIDTH(8), .NCS(4))  if0 ();
  spi_master_multi_if #(.WIDTH(16), .NCS(3)) if1 ();

  spi_master_multi #(.WIDTH(8), .DIV(4), .NCS(4), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n0), .bus(if0.master));
  spi_master_multi #(.WIDTH(16), .DIV(1), .NCS(3), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n1), .bus(if1.master));

  // Mode-3 slave on CS[3]: drives on falling SCLK, captures on rising SCLK.
  logic       slave_en = 1'b0;
  logic       slave_miso = 1'b0;
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  always @(negedge if0.SCLK) if (slave_en && !if0.CS[3]) begin
    slave_miso = slave_tx[7];
    slave_tx   = slave_tx << 1;
  end
  always @(posedge if0.SCLK) if (slave_en && !if0.CS[3]) slave_rx = {slave_rx[6:0], if0.MOSI};

  assign if0.MISO = slave_en ? slave_miso : if0.MOSI;
  assign if1.MISO = if1.MOSI;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [1:0] sel;
    logic [7:0] data;
    logic       slave;
    logic [7:0] stx;
    logic       poke;
    logic [7:0] exp_rx;
    logic [7:0] exp_srx;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet0(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (if0.arrived || if0.CS != 4'hF || !if0.ready) bad++;
    end
  endtask

  task automatic xfer0(input vec_t v);
    int   arr_k, cs_low, cs_bad, rises, viol, first_sclk, first_mosi, qbad;
    logic ps, pm, lead, first_val, sclk0, ready0;
    slave_en = v.slave;
    slave_tx = v.stx;
    slave_rx = 8'h00;
    if0.cpol = v.cpol; if0.cpha = v.cpha; if0.sel = v.sel; if0.data = v.data;
    if0.send = 1'b1;
    tick();
    if0.send = 1'b0;
    arr_k = -1; cs_low = 0; cs_bad = 0; rises = 0; viol = 0;
    first_sclk = -1; first_mosi = -1; first_val = 1'b0;
    ps = if0.SCLK; pm = if0.MOSI; sclk0 = if0.SCLK; ready0 = if0.ready;
    for (int k = 0; k <= 200; k++) begin
      if (k > 0) tick();
      if (v.poke && k == 10) begin if0.send = 1'b1; if0.sel = v.sel + 2'd1; if0.data = 8'hFF; end
      if (v.poke && k == 11) if0.send = 1'b0;
      if (if0.CS != 4'hF) begin
        cs_low++;
        if (if0.CS != ~(4'b0001 << v.sel)) cs_bad++;
      end
      lead = (if0.SCLK != v.cpol);
      if (if0.SCLK != ps) begin
        if (if0.SCLK && !ps) rises++;
        if (first_sclk < 0) begin first_sclk = k; first_val = if0.SCLK; end
      end
      if (k > 0 && if0.MOSI != pm) begin
        if (first_mosi < 0) first_mosi = k;
        if (if0.SCLK == ps) viol++;
        else if ((v.cpha == 1'b0) == lead) viol++;
      end
      ps = if0.SCLK; pm = if0.MOSI;
      if (if0.arrived) begin arr_k = k; break; end
    end
    check("latency", arr_k, 72);
    check("dataO", if0.dataO, v.exp_rx);
    check("cs_low_cycles", cs_low, 72);
    check("cs_only_sel", cs_bad, 0);
    check("sclk_rises", rises, 8);
    check("mosi_timing", viol, 0);
    check("sclk_setup_level", sclk0, v.cpol);
    check("ready_busy", ready0, 1'b0);
    if (v.slave) begin
      check("slave_rx", slave_rx, v.exp_srx);
      check("first_mosi_on_first_edge", first_mosi, first_sclk);
      check("first_edge_falling", first_val, 1'b0);
    end
    quiet0(10, qbad);
    check("post_arrived_quiet", qbad, 0);
    check("sclk_idle_level", if0.SCLK, v.cpol);
    slave_en = 1'b0;
  endtask

  initial begin
    int a1, a2, qbad, arr, idx;
    logic [7:0]  d1, d2;
    logic [3:0]  cs_a1, cs_a1p;
    logic [15:0] bits;
    logic        ps;

    vecs[0] = '{cpol:1'b1, cpha:1'b1, sel:2'd3, data:8'hAA, slave:1'b1, stx:8'h2B, poke:1'b0, exp_rx:8'h2B, exp_srx:8'hAA};
    vecs[1] = '{cpol:1'b0, cpha:1'b0, sel:2'd2, data:8'h42, slave:1'b0, stx:8'h00, poke:1'b0, exp_rx:8'h42, exp_srx:8'h00};
    vecs[2] = '{cpol:1'b0, cpha:1'b1, sel:2'd0, data:8'h5A, slave:1'b0, stx:8'h00, poke:1'b1, exp_rx:8'h5A, exp_srx:8'h00};
    vecs[3] = '{cpol:1'b1, cpha:1'b0, sel:2'd1, data:8'hC3, slave:1'b0, stx:8'h00, poke:1'b0, exp_rx:8'hC3, exp_srx:8'h00};

    rst_n0 = 1'b0; rst_n1 = 1'b0;
    if0.send = 1'b0; if0.data = '0; if0.sel = '0; if0.cpol = 1'b0; if0.cpha = 1'b0;
    if1.send = 1'b0; if1.data = '0; if1.sel = '0; if1.cpol = 1'b0; if1.cpha = 1'b0;
    #22;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    tick();
    check("rst_ready", if0.ready, 1'b1);
    check("rst_arrived", if0.arrived, 1'b0);
    check("rst_dataO", if0.dataO, 8'h00);
    check("rst_sclk", if0.SCLK, 1'b0);
    check("rst_mosi", if0.MOSI, 1'b0);
    check("rst_cs", if0.CS, 4'hF);

    for (int i = 0; i < 4; i++) xfer0(vecs[i]);

    // Abort mid-transfer with an asynchronous reset.
    if0.cpol = 1'b0; if0.cpha = 1'b0; if0.sel = 2'd2; if0.data = 8'h99; if0.send = 1'b1;
    tick();
    if0.send = 1'b0;
    repeat (20) tick();
    check("abort_cs_before", if0.CS, 4'hB);
    #2 rst_n0 = 1'b0;
    #1;
    check("abort_cs", if0.CS, 4'hF);
    check("abort_sclk", if0.SCLK, 1'b0);
    check("abort_ready", if0.ready, 1'b1);
    check("abort_dataO", if0.dataO, 8'h00);
    @(negedge clk);
    rst_n0 = 1'b1;
    quiet0(100, qbad);
    check("abort_no_arrived", qbad, 0);

    // Back-to-back: send held through the first arrived cycle.
    if0.cpol = 1'b0; if0.cpha = 1'b0; if0.sel = 2'd1; if0.data = 8'h01; if0.send = 1'b1;
    tick();
    a1 = -1; a2 = -1; d1 = 8'h00; d2 = 8'h00; cs_a1 = 4'h0; cs_a1p = 4'h0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (a1 >= 0 && k == a1 + 1) begin cs_a1p = if0.CS; if0.send = 1'b0; end
      if (if0.arrived) begin
        if (a1 < 0) begin a1 = k; d1 = if0.dataO; cs_a1 = if0.CS; if0.data = 8'h80; end
        else begin a2 = k; d2 = if0.dataO; break; end
      end
    end
    if0.send = 1'b0;
    check("b2b_first_latency", a1, 72);
    check("b2b_second_latency", a2 - a1 - 1, 72);
    check("b2b_first_data", d1, 8'h01);
    check("b2b_second_data", d2, 8'h80);
    check("b2b_cs_arrived_cycle", cs_a1, 4'hF);
    check("b2b_cs_next_cycle", cs_a1p, 4'hD);
    quiet0(10, qbad);
    check("b2b_quiet", qbad, 0);

    // 16-bit, DIV=1, LSB first, mode 1 loopback.
    if1.cpol = 1'b0; if1.cpha = 1'b1; if1.sel = 2'd0; if1.data = 16'h1234; if1.send = 1'b1;
    tick();
    if1.send = 1'b0;
    ps = if1.SCLK; bits = 16'h0000; idx = 0; arr = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (if1.SCLK && !ps) begin
        if (idx < 16) bits[idx] = if1.MOSI;
        idx++;
      end
      ps = if1.SCLK;
      if (if1.arrived) begin arr = k; break; end
    end
    check("w16_latency", arr, 34);
    check("w16_dataO", if1.dataO, 16'h1234);
    check("w16_lsb_first_stream", bits, 16'h1234);
    check("w16_leading_edges", idx, 16);

    // Out-of-range chip select is dropped.
    tick();
    if1.sel = 2'd3; if1.data = 16'hFFFF; if1.send = 1'b1;
    tick();
    if1.send = 1'b0;
    qbad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!if1.ready || if1.arrived || if1.CS != 3'h7) qbad++;
      tick();
    end
    check("bad_sel_dropped", qbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
